// File: rtl/packet_demux.sv
// packet_demux: routes whole packets from one valid/ready stream to one of
// N_OUT registered single-entry output buffers, chosen by the head beat's select.
module packet_demux #(
  parameter int unsigned N_OUT = 4,
  parameter int unsigned W     = 8,
  parameter int unsigned SEL_W = $clog2(N_OUT) + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               up_valid,
  output logic               up_ready,
  input  logic [W-1:0]       up_data,
  input  logic               up_last,
  input  logic [SEL_W-1:0]   up_sel,
  output logic [N_OUT-1:0]   dn_valid,
  input  logic [N_OUT-1:0]   dn_ready,
  output logic [N_OUT*W-1:0] dn_data,
  output logic [N_OUT-1:0]   dn_last,
  output logic               busy,
  output logic [7:0]         drop_cnt
);

  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    ST_HEAD = 2'd0,
    ST_FWD  = 2'd1,
    ST_DROP = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [SEL_W-1:0]     cur_port_q, cur_port_d;
  logic [CNT_W-1:0]     drop_cnt_q, drop_cnt_d;
  logic [N_OUT-1:0]     dn_valid_q;
  logic [N_OUT-1:0]     dn_last_q;
  logic [N_OUT*W-1:0]   dn_data_q;

  logic [SEL_W-1:0]     tgt;
  logic                 tgt_in_range;
  logic                 tgt_free;
  logic                 load_en;

  // Target port of the current beat and whether its buffer can take a beat this cycle
  always_comb begin
    tgt          = (state_q == ST_HEAD) ? up_sel : cur_port_q;
    tgt_in_range = (tgt < SEL_W'(N_OUT));
    tgt_free     = 1'b0;
    for (int unsigned i = 0; i < N_OUT; i++) begin
      if (tgt == SEL_W'(i)) begin
        tgt_free = !dn_valid_q[i] || dn_ready[i];
      end
    end
  end

  // Packet FSM next state, upstream handshake and drop accounting
  always_comb begin
    state_d    = state_q;
    cur_port_d = cur_port_q;
    drop_cnt_d = drop_cnt_q;
    up_ready   = 1'b0;
    load_en    = 1'b0;
    if (rst_n) begin
      case (state_q)
        ST_HEAD: begin
          if (tgt_in_range) begin
            up_ready = tgt_free;
            if (up_valid && tgt_free) begin
              load_en    = 1'b1;
              cur_port_d = up_sel;
              if (!up_last) state_d = ST_FWD;
            end
          end else begin
            up_ready = 1'b1;
            if (up_valid) begin
              if (drop_cnt_q != {CNT_W{1'b1}}) drop_cnt_d = drop_cnt_q + CNT_W'(1);
              if (!up_last) state_d = ST_DROP;
            end
          end
        end
        ST_FWD: begin
          up_ready = tgt_free;
          if (up_valid && tgt_free) begin
            load_en = 1'b1;
            if (up_last) state_d = ST_HEAD;
          end
        end
        ST_DROP: begin
          up_ready = 1'b1;
          if (up_valid && up_last) state_d = ST_HEAD;
        end
        default: state_d = ST_HEAD;
      endcase
    end
  end

  // FSM state, latched port and drop counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_HEAD;
      cur_port_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      cur_port_q <= cur_port_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Output buffers: a new beat wins over a same-cycle drain, so full throughput has no bubble
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dn_valid_q <= '0;
      dn_last_q  <= '0;
      dn_data_q  <= '0;
    end else begin
      for (int unsigned i = 0; i < N_OUT; i++) begin
        if (load_en && (tgt == SEL_W'(i))) begin
          dn_valid_q[i]        <= 1'b1;
          dn_last_q[i]         <= up_last;
          dn_data_q[i*W +: W]  <= up_data;
        end else if (dn_ready[i]) begin
          dn_valid_q[i] <= 1'b0;
        end
      end
    end
  end

  assign dn_valid = dn_valid_q;
  assign dn_data  = dn_data_q;
  assign dn_last  = dn_last_q;
  assign busy     = (state_q != ST_HEAD);
  assign drop_cnt = drop_cnt_q;

endmodule
